// File: rtl/counter_gen_modal.sv
// Prescaled modal counter: up-wrap, down-wrap, bounce or hold between GEN_MIN and GEN_MAX.
// Define COUNTER_GEN_BCD_EN to count in packed BCD instead of binary.
module counter_gen_modal #(
  parameter int                CNT_W   = 26,
  parameter logic [CNT_W-1:0]  CNT_MAX = 26'd49_999_999,
  parameter int                DATA_W  = 20,
  parameter logic [DATA_W-1:0] GEN_MIN = 20'd0,
  parameter logic [DATA_W-1:0] GEN_MAX = 20'd999_999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              neg,
  output logic              tick,
  output logic              wrap,
  output logic              dir
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] SPAN     = GEN_MAX - GEN_MIN;
  localparam bit                DEGEN    = (GEN_MIN == GEN_MAX);

`ifdef COUNTER_GEN_BCD_EN
  function automatic logic [DATA_W-1:0] step_up(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DATA_W / 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] step_down(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DATA_W / 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [DATA_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DATA_W / 4; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction
`else
  function automatic logic [DATA_W-1:0] step_up(input logic [DATA_W-1:0] v);
    return v + DATA_ONE;
  endfunction

  function automatic logic [DATA_W-1:0] step_down(input logic [DATA_W-1:0] v);
    return v - DATA_ONE;
  endfunction
`endif

  mode_e             mode_s;
  logic [CNT_W-1:0]  presc_r, presc_nxt_s;
  logic [DATA_W-1:0] data_r, data_nxt_s, load_off_s, load_val_s;
  logic              neg_r, wrap_r, dir_r;
  logic              dir_nxt_s, wrap_nxt_s, tick_s, load_ok_s;

  assign mode_s = mode_e'(mode);
  assign tick_s = en && (presc_r == CNT_MAX);

  // Out-of-range test as one unsigned offset compare, so GEN_MIN==0 needs no special case.
  assign load_off_s = load_data - GEN_MIN;
`ifdef COUNTER_GEN_BCD_EN
  assign load_ok_s  = (load_off_s <= SPAN) && digits_ok(load_data);
`else
  assign load_ok_s  = (load_off_s <= SPAN);
`endif
  assign load_val_s = load_ok_s ? load_data : GEN_MIN;

  // Prescaler next value: free-run to CNT_MAX, freeze while disabled.
  always_comb begin
    presc_nxt_s = presc_r;
    if (en) begin
      if (presc_r == CNT_MAX) begin
        presc_nxt_s = {CNT_W{1'b0}};
      end else begin
        presc_nxt_s = presc_r + CNT_ONE;
      end
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Count step applied at the end of a tick cycle.
  always_comb begin
    data_nxt_s = data_r;
    dir_nxt_s  = dir_r;
    wrap_nxt_s = 1'b0;
    case (mode_s)
      MODE_UP: begin
        dir_nxt_s = 1'b0;
        if (data_r == GEN_MAX) begin
          data_nxt_s = GEN_MIN;
          wrap_nxt_s = 1'b1;
        end else begin
          data_nxt_s = step_up(data_r);
        end
      end
      MODE_DOWN: begin
        dir_nxt_s = 1'b1;
        if (data_r == GEN_MIN) begin
          data_nxt_s = GEN_MAX;
          wrap_nxt_s = 1'b1;
        end else begin
          data_nxt_s = step_down(data_r);
        end
      end
      MODE_BOUNCE: begin
        if (!dir_r) begin
          if (data_r == GEN_MAX) begin
            data_nxt_s = DEGEN ? GEN_MAX : step_down(GEN_MAX);
            dir_nxt_s  = 1'b1;
            wrap_nxt_s = 1'b1;
          end else begin
            data_nxt_s = step_up(data_r);
          end
        end else begin
          if (data_r == GEN_MIN) begin
            data_nxt_s = DEGEN ? GEN_MIN : step_up(GEN_MIN);
            dir_nxt_s  = 1'b0;
            wrap_nxt_s = 1'b1;
          end else begin
            data_nxt_s = step_down(data_r);
          end
        end
      end
      MODE_HOLD: begin
        data_nxt_s = data_r;
      end
      default: begin
        data_nxt_s = data_r;
      end
    endcase
  end

  // State register: reset beats load, load beats a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {CNT_W{1'b0}};
      data_r  <= GEN_MIN;
      neg_r   <= 1'b0;
      wrap_r  <= 1'b0;
      dir_r   <= 1'b0;
    end else if (load) begin
      presc_r <= {CNT_W{1'b0}};
      data_r  <= load_val_s;
      wrap_r  <= 1'b0;
    end else begin
      presc_r <= presc_nxt_s;
      if (tick_s) begin
        data_r <= data_nxt_s;
        dir_r  <= dir_nxt_s;
        wrap_r <= wrap_nxt_s;
        neg_r  <= ~neg_r;
      end else begin
        wrap_r <= 1'b0;
      end
    end
  end

  assign data = data_r;
  assign neg  = neg_r;
  assign wrap = wrap_r;
  assign dir  = dir_r;
  assign tick = tick_s;

endmodule

// File: tb/tb_counter_gen_modal.sv
// Directed scoreboard bench for counter_gen_modal (CNT_MAX=3, DATA_W=8).
// Binary range 0..9 by default; BCD range 00..59 when COUNTER_GEN_BCD_EN is defined.
module tb_counter_gen_modal;

`ifdef COUNTER_GEN_BCD_EN
  localparam logic [7:0] GMAX = 8'h59;
`else
  localparam logic [7:0] GMAX = 8'd9;
`endif

  logic       clk = 1'b0;
  logic       rst, en, load, neg, tick, wrap, dir;
  logic [1:0] mode;
  logic [7:0] load_data, data;

  typedef struct packed {
    logic [7:0] d;
    logic       w;
    logic       dr;
  } exp_t;

  exp_t sb[$];
  int   passed = 0, failed = 0, total = 0;
  int   cyc_no = 0, last_tick_cyc = 0;
  logic neg_exp = 1'b0;

  counter_gen_modal #(
    .CNT_W(26), .CNT_MAX(26'd3), .DATA_W(8), .GEN_MIN(8'd0), .GEN_MAX(GMAX)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_data(load_data),
    .data(data), .neg(neg), .tick(tick), .wrap(wrap), .dir(dir)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic push(input logic [7:0] d, input logic w, input logic dr);
    sb.push_back(exp_t'{d: d, w: w, dr: dr});
  endtask

  task automatic next_tick(input string tag, output int gap);
    int start;
    start = last_tick_cyc;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tick === 1'b1) break;
    end
    chk({tag, "_tick"}, 32'(tick), 32'd1);
    gap = cyc_no - start;
    last_tick_cyc = cyc_no;
  endtask

  task automatic step_check(input string tag, input int exp_gap);
    exp_t e;
    int   gap;
    next_tick(tag, gap);
    chk({tag, "_period"}, 32'(gap), 32'(exp_gap));
    cycle();
    neg_exp = ~neg_exp;
    e = sb.pop_front();
    chk({tag, "_data"}, 32'(data), 32'(e.d));
    chk({tag, "_wrap"}, 32'(wrap), 32'(e.w));
    chk({tag, "_dir"},  32'(dir),  32'(e.dr));
    chk({tag, "_neg"},  32'(neg),  32'(neg_exp));
    if (e.w) begin
      cycle();
      chk({tag, "_wrap_clr"}, 32'(wrap), 32'd0);
    end
  endtask

  task automatic do_load(input string tag, input logic [7:0] v, input logic [7:0] exp_d);
    load = 1'b1;
    load_data = v;
    last_tick_cyc = cyc_no;
    cycle();
    load = 1'b0;
    chk({tag, "_data"}, 32'(data), 32'(exp_d));
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_neg"},  32'(neg),  32'(neg_exp));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_neg"},  32'(neg),  32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_dir"},  32'(dir),  32'd0);
  endtask

  initial begin
    int gap, tk;
    logic [7:0] held;
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_data = 8'd0;
    repeat (3) cycle();
    check_reset("reset");

    // First tick falls in the fourth cycle after the last reset edge.
    rst = 1'b0; en = 1'b1; last_tick_cyc = cyc_no;
`ifdef COUNTER_GEN_BCD_EN
    cycle();
    do_load("bcd_ld08", 8'h08, 8'h08);
    push(8'h09, 1'b0, 1'b0); step_check("bcd_up09", 4);
    push(8'h10, 1'b0, 1'b0); step_check("bcd_up10", 4);
    do_load("bcd_ld58", 8'h58, 8'h58);
    push(8'h59, 1'b0, 1'b0); step_check("bcd_up59", 4);
    push(8'h00, 1'b1, 1'b0); step_check("bcd_wrap", 4);
    mode = 2'b01;
    do_load("bcd_ld10", 8'h10, 8'h10);
    push(8'h09, 1'b0, 1'b1); step_check("bcd_dn09", 4);
    do_load("bcd_ld_bad_nib", 8'h1A, 8'h00);
    do_load("bcd_ld_over", 8'h60, 8'h00);
`else
    for (int i = 1; i <= 10; i++) begin
      push(8'(i % 10), (i == 10), 1'b0);
      step_check("up", (i == 1) ? 3 : 4);
    end

    // Mode change alone must not move data.
    mode = 2'b01;
    cycle();
    chk("mode_chg_hold_data", 32'(data), 32'd0);
    push(8'd9, 1'b1, 1'b1); step_check("down_wrap", 4);
    push(8'd8, 1'b0, 1'b1); step_check("down8", 4);
    push(8'd7, 1'b0, 1'b1); step_check("down7", 4);

    mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      push(8'd7, 1'b0, 1'b1);
      step_check("hold", 4);
    end

    // One up step clears dir before bounce.
    mode = 2'b00;
    do_load("ld7", 8'd7, 8'd7);
    push(8'd8, 1'b0, 1'b0); step_check("up8", 4);
    mode = 2'b10;
    push(8'd9, 1'b0, 1'b0); step_check("bnc9", 4);
    push(8'd8, 1'b1, 1'b1); step_check("bnc_top", 4);
    for (int v = 7; v >= 0; v--) begin
      push(8'(v), 1'b0, 1'b1);
      step_check("bnc_down", 4);
    end
    push(8'd1, 1'b1, 1'b0); step_check("bnc_bot", 4);
    push(8'd2, 1'b0, 1'b0); step_check("bnc2", 4);

    // Load coinciding with a tick: no step, prescaler restarts.
    next_tick("drop", gap);
    load = 1'b1; load_data = 8'd5; last_tick_cyc = cyc_no;
    cycle();
    load = 1'b0;
    chk("ld_on_tick_data", 32'(data), 32'd5);
    chk("ld_on_tick_wrap", 32'(wrap), 32'd0);
    chk("ld_on_tick_neg",  32'(neg),  32'(neg_exp));
    push(8'd6, 1'b0, 1'b0); step_check("after_drop", 4);

    do_load("ld9", 8'd9, 8'd9);
    push(8'd8, 1'b1, 1'b1); step_check("bnc_ld_top", 4);
    mode = 2'b00;
    do_load("ld12", 8'd12, 8'd0);
    push(8'd1, 1'b0, 1'b0); step_check("up_after_ld", 4);

    // Freeze prescaler at 1 for 10 cycles; it resumes two cycles short of a tick.
    cycle();
    en = 1'b0;
    held = data;
    tk = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (tick === 1'b1) tk++;
    end
    chk("en_low_no_tick", 32'(tk), 32'd0);
    chk("en_low_data", 32'(data), 32'(held));
    en = 1'b1; last_tick_cyc = cyc_no;
    push(8'd2, 1'b0, 1'b0); step_check("resume", 2);

    // Reset pulse while prescaler is 2.
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check_reset("mid_reset");
    rst = 1'b0; last_tick_cyc = cyc_no; neg_exp = 1'b0;
    push(8'd1, 1'b0, 1'b0); step_check("post_reset", 3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_gen_modal.md
COUNTER_GEN_MODAL -- requirements
Module: counter_gen_modal

Interface
REQ-001 SHALL have parameter CNT_W, default 26, meaning prescaler width.
REQ-002 SHALL have parameter CNT_MAX, default 26'd49_999_999, meaning tick period minus one, in clk cycles.
REQ-003 SHALL have parameter DATA_W, default 20, meaning data width.
REQ-004 SHALL have parameter GEN_MIN, default 0, meaning lower count bound.
REQ-005 SHALL have parameter GEN_MAX, default 999_999, meaning upper count bound.
REQ-006 SHALL have port clk  input  1  meaning system clock; one clock only, all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  meaning reset; synchronous, active-high.
REQ-008 SHALL have port en  input  1  meaning run enable for the prescaler.
REQ-009 SHALL have port mode  input  2  meaning 00 up-wrap, 01 down-wrap, 10 bounce, 11 hold.
REQ-010 SHALL have port load  input  1  meaning synchronous load strobe.
REQ-011 SHALL have port load_data  input  DATA_W  meaning value to load.
REQ-012 SHALL have port data  output  DATA_W  meaning current count.
REQ-013 SHALL have port neg  output  1  meaning level that toggles on every tick.
REQ-014 SHALL have port tick  output  1  meaning one-cycle prescaler pulse.
REQ-015 SHALL have port wrap  output  1  meaning one-cycle pulse on a bound event.
REQ-016 SHALL have port dir  output  1  meaning current direction, 0 up, 1 down.

Function
REQ-017 The prescaler SHALL count 0..CNT_MAX while en=1, wrap to 0 after CNT_MAX, and hold its value while en=0.
REQ-018 tick SHALL be high for exactly the cycle in which the prescaler equals CNT_MAX with en=1, giving a period of CNT_MAX+1 cycles.
REQ-019 data, neg, dir and wrap SHALL update at the clk edge that ends a tick cycle and at no other edge, except on load or reset.
REQ-020 In up-wrap mode, data SHALL be incremented by 1; when data==GEN_MAX it SHALL go to GEN_MIN, wrap SHALL be 1 for one cycle, and dir SHALL be 0.
REQ-021 In down-wrap mode, data SHALL be decremented by 1; when data==GEN_MIN it SHALL go to GEN_MAX, wrap SHALL be 1 for one cycle, and dir SHALL be 1.
REQ-022 In bounce mode, data SHALL step in the direction given by dir.
REQ-023 In bounce mode, when going up and data==GEN_MAX, data SHALL go to GEN_MAX-1, dir SHALL go to 1, and wrap SHALL pulse.
REQ-024 In bounce mode, when going down and data==GEN_MIN, data SHALL go to GEN_MIN+1, dir SHALL go to 0, and wrap SHALL pulse.
REQ-025 In hold mode, data SHALL stay unchanged and no wrap SHALL occur.
REQ-026 neg SHALL toggle on every tick in all modes, including hold.
REQ-027 A mode change SHALL take effect on the next tick, and data SHALL NOT change when mode changes.
REQ-028 On load=1, data SHALL take load_data if GEN_MIN<=load_data<=GEN_MAX, otherwise GEN_MIN.
REQ-029 On load=1, the prescaler SHALL go to 0, neg SHALL be unchanged, and wrap SHALL be 0.
REQ-030 load SHALL take priority over a simultaneous tick: the tick is dropped and the next tick comes CNT_MAX+1 cycles later.
REQ-031 All arithmetic SHALL be modulo DATA_W, and data SHALL never leave [GEN_MIN, GEN_MAX] after reset or load.
REQ-032 When GEN_MIN==GEN_MAX, data SHALL stay constant and wrap SHALL pulse on every tick in up-wrap, down-wrap and bounce modes.
REQ-033 The design SHALL require GEN_MIN<=GEN_MAX and CNT_MAX>=1; other parameter values are out of scope.

Reset
REQ-034 When rst=1 at a clk edge, the block SHALL set prescaler=0, data=GEN_MIN, neg=0, tick=0, wrap=0 and dir=0, regardless of en, load or the current state.
REQ-035 rst SHALL take priority over load and tick.
REQ-036 Reset mid-period SHALL restart a full CNT_MAX+1 period.

Configuration
REQ-037 When macro COUNTER_GEN_BCD_EN is defined, data SHALL count in packed BCD, each nibble 0-9 with decimal carry and borrow.
REQ-038 With COUNTER_GEN_BCD_EN defined, GEN_MIN, GEN_MAX and load_data SHALL be BCD-coded, a load_data with any nibble >9 SHALL load GEN_MIN, and DATA_W SHALL be a multiple of 4.
REQ-039 When COUNTER_GEN_BCD_EN is not defined, counting SHALL be plain binary and no BCD logic SHALL exist.

Verification (CNT_MAX=3, GEN_MIN=0, GEN_MAX=9, binary unless stated)
REQ-040 Bench SHALL check reset then up-wrap: release rst, en=1, mode=00 -> tick every 4 cycles, data 0,1..9,0, wrap pulse on the 9->0 step, neg toggles each tick.
REQ-041 Bench SHALL check down-wrap and hold: mode=01 from data=0 -> data 9,8..; then mode=11 -> data holds while neg keeps toggling and wrap stays 0.
REQ-042 Bench SHALL check bounce: mode=10 from data=8 -> 9,8,7..0,1 with dir 0->1 at 9 and 1->0 at 0, wrap pulse at each turn.
REQ-043 Bench SHALL check load and the simultaneous-tick case: load=1, load_data=5 on a tick cycle -> data=5, no step, next tick 4 cycles later; load_data=12 -> data=0.
REQ-044 Bench SHALL check en low and reset mid-period: en=0 for 10 cycles -> no tick and prescaler frozen; rst pulse at prescaler=2 -> all outputs at reset values and the next tick 4 cycles after rst falls.
REQ-045 Bench SHALL check BCD mode: with COUNTER_GEN_BCD_EN, DATA_W=8, GEN_MAX=8'h59, up-wrap -> 8'h09 then 8'h10, 8'h59 then 8'h00 with wrap; down-wrap 8'h10 -> 8'h09.
